// File: rtl/dp_detect_filter_mfc_if.sv
// Handshake bundle between the MFC DP-matching stage and its detection filter.
interface dp_detect_filter_mfc_if #(
  parameter int BIT = 32
);
  logic              frame_dv;
  logic              hit;
  logic              vad;
  logic [BIT+12:0]   scr_in;
  logic [6:0]        len_in;
  logic              det_pulse;
  logic [BIT+12:0]   det_scr;
  logic [6:0]        det_len;
  logic [7:0]        det_cnt;
  logic              busy;

  modport master (
    output frame_dv, hit, vad, scr_in, len_in,
    input  det_pulse, det_scr, det_len, det_cnt, busy
  );

  modport slave (
    input  frame_dv, hit, vad, scr_in, len_in,
    output det_pulse, det_scr, det_len, det_cnt, busy
  );
endinterface

// File: rtl/dp_detect_filter_mfc.sv
// Debounced keyword-detection filter behind the MFC DP matcher.
// Optional macro DETECT_ONCE_PER_VAD_EN: allow one detection per voiced segment.
module dp_detect_filter_mfc #(
  parameter int BIT     = 32,
  parameter int MINHITS = 3,
  parameter int HOLDOFF = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  dp_detect_filter_mfc_if.slave  bus
);

  localparam int SW = BIT + 13;
  localparam int PW = BIT + 20;
  localparam logic [3:0] MINHITS_C = 4'(MINHITS);
  localparam logic [7:0] HOLDOFF_C = 8'(HOLDOFF);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LISTEN = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [1:0]    state_r;
  logic [3:0]    run_cnt_r;
  logic [7:0]    hold_cnt_r;
  logic          best_vld_r;
  logic [SW-1:0] best_scr_r;
  logic [6:0]    best_len_r;
  logic          det_pulse_r;
  logic [SW-1:0] det_scr_r;
  logic [6:0]    det_len_r;
  logic [7:0]    det_cnt_r;
  logic          busy_r;

  logic          hit_ok_s;
  logic          take_s;
  logic          run_done_s;
  logic          hold_exit_s;
  logic [3:0]    run_inc_s;
  logic [PW-1:0] prod_new_s;
  logic [PW-1:0] prod_best_s;
  logic [SW-1:0] cand_scr_s;
  logic [6:0]    cand_len_s;

`ifdef DETECT_ONCE_PER_VAD_EN
  // Expired hold parks in HOLD until the segment ends.
  assign hold_exit_s = 1'b0;
`else
  assign hold_exit_s = (hold_cnt_r == 8'd1);
`endif

  // Frame qualification and ratio compare (cross-multiplied, so no divider).
  always_comb begin
    hit_ok_s    = bus.hit && (bus.len_in != 7'd0);
    prod_new_s  = PW'(bus.scr_in) * PW'(best_len_r);
    prod_best_s = PW'(best_scr_r) * PW'(bus.len_in);
    if (!best_vld_r) begin
      take_s = 1'b1;
    end else begin
      take_s = (prod_new_s < prod_best_s);
    end
    if (take_s) begin
      cand_scr_s = bus.scr_in;
      cand_len_s = bus.len_in;
    end else begin
      cand_scr_s = best_scr_r;
      cand_len_s = best_len_r;
    end
    run_inc_s  = run_cnt_r + 4'd1;
    run_done_s = (run_inc_s == MINHITS_C);
  end

  // Filter state machine, run/hold counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      run_cnt_r   <= 4'd0;
      hold_cnt_r  <= 8'd0;
      best_vld_r  <= 1'b0;
      best_scr_r  <= '0;
      best_len_r  <= 7'd0;
      det_pulse_r <= 1'b0;
      det_scr_r   <= '0;
      det_len_r   <= 7'd0;
      det_cnt_r   <= 8'd0;
      busy_r      <= 1'b0;
    end else begin
      det_pulse_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          run_cnt_r  <= 4'd0;
          hold_cnt_r <= 8'd0;
          best_vld_r <= 1'b0;
          if (bus.vad) begin
            state_r <= ST_LISTEN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_LISTEN: begin
          if (!bus.vad) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            run_cnt_r  <= 4'd0;
            hold_cnt_r <= 8'd0;
            best_vld_r <= 1'b0;
          end else if (bus.frame_dv && hit_ok_s) begin
            if (run_done_s) begin
              det_pulse_r <= 1'b1;
              det_scr_r   <= cand_scr_s;
              det_len_r   <= cand_len_s;
              det_cnt_r   <= (det_cnt_r == 8'd255) ? 8'd255 : det_cnt_r + 8'd1;
              run_cnt_r   <= 4'd0;
              best_vld_r  <= 1'b0;
              hold_cnt_r  <= HOLDOFF_C;
              state_r     <= ST_HOLD;
            end else begin
              run_cnt_r  <= run_inc_s;
              best_vld_r <= 1'b1;
              best_scr_r <= cand_scr_s;
              best_len_r <= cand_len_s;
            end
          end else if (bus.frame_dv) begin
            run_cnt_r  <= 4'd0;
            best_vld_r <= 1'b0;
          end else begin
            run_cnt_r <= run_cnt_r;
          end
        end
        ST_HOLD: begin
          if (!bus.vad) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            run_cnt_r  <= 4'd0;
            hold_cnt_r <= 8'd0;
            best_vld_r <= 1'b0;
          end else if (bus.frame_dv && (hold_cnt_r != 8'd0)) begin
            hold_cnt_r <= hold_cnt_r - 8'd1;
            if (hold_exit_s) begin
              state_r <= ST_LISTEN;
            end else begin
              state_r <= ST_HOLD;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          run_cnt_r  <= 4'd0;
          hold_cnt_r <= 8'd0;
          best_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.det_pulse = det_pulse_r;
  assign bus.det_scr   = det_scr_r;
  assign bus.det_len   = det_len_r;
  assign bus.det_cnt   = det_cnt_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_dp_detect_filter_mfc.sv
// Directed-vector bench for dp_detect_filter_mfc (MINHITS=3, HOLDOFF=4).
module tb_dp_detect_filter_mfc;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   pulse_cnt = 0;
  int   exp_pulses = 0;
  int   exp_cnt = 0;
  int   base;
  logic [9:0] pat;

  localparam logic [44:0] BIG = 45'h0FFF_FFFF_FFFF;

  dp_detect_filter_mfc_if #(.BIT(32)) ifc ();

  dp_detect_filter_mfc #(.BIT(32), .MINHITS(3), .HOLDOFF(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifc.det_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic dv, input logic h,
                       input logic [44:0] s, input logic [6:0] l);
    @(negedge clk);
    ifc.vad = v; ifc.frame_dv = dv; ifc.hit = h; ifc.scr_in = s; ifc.len_in = l;
    @(posedge clk);
    #1;
  endtask

  task automatic frm(input logic h, input logic [44:0] s, input logic [6:0] l);
    drive(1'b1, 1'b1, h, s, l);
  endtask

  task automatic idle_cyc(input logic v);
    drive(v, 1'b0, 1'b0, 45'd0, 7'd0);
  endtask

  task automatic expect_hit(input string tag);
    check(tag, ifc.det_pulse, 64'd1);
    exp_pulses++;
    exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
  endtask

  initial begin
    ifc.vad = 1'b0; ifc.frame_dv = 1'b0; ifc.hit = 1'b0;
    ifc.scr_in = 45'd0; ifc.len_in = 7'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pulse", ifc.det_pulse, 64'd0);
    check("rst_scr",   ifc.det_scr,   64'd0);
    check("rst_len",   ifc.det_len,   64'd0);
    check("rst_cnt",   ifc.det_cnt,   64'd0);
    check("rst_busy",  ifc.busy,      64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic detection, best score 600/10
    idle_cyc(1'b1);
    check("busy_rise", ifc.busy, 64'd1);
    frm(1'b1, 45'd900, 7'd10); check("t1_f1", ifc.det_pulse, 64'd0);
    frm(1'b1, 45'd600, 7'd10); check("t1_f2", ifc.det_pulse, 64'd0);
    frm(1'b1, 45'd800, 7'd10); expect_hit("t1_f3");
    check("t1_scr", ifc.det_scr, 64'd600);
    check("t1_len", ifc.det_len, 64'd10);
    check("t1_cnt", ifc.det_cnt, 64'(exp_cnt));
    idle_cyc(1'b1);
    check("t1_onecyc", ifc.det_pulse, 64'd0);
    idle_cyc(1'b0);
    check("t1_busy_fall", ifc.busy, 64'd0);
    check("t1_scr_kept", ifc.det_scr, 64'd600);

    // Ratio compare with differing lengths and a tie
    idle_cyc(1'b1);
    frm(1'b1, 45'd500, 7'd10);
    frm(1'b1, 45'd330, 7'd6);
    frm(1'b1, 45'd700, 7'd14); expect_hit("t2_pulse");
    check("t2_scr", ifc.det_scr, 64'd500);
    check("t2_len", ifc.det_len, 64'd10);
    idle_cyc(1'b0);

    // Full-width products
    idle_cyc(1'b1);
    frm(1'b1, BIG, 7'd127);
    frm(1'b1, BIG - 45'd1, 7'd127);
    frm(1'b1, BIG, 7'd127); expect_hit("t3_pulse");
    check("t3_scr", ifc.det_scr, 64'(BIG - 45'd1));
    check("t3_len", ifc.det_len, 64'd127);
    idle_cyc(1'b0);

    // Hits 1,1,0,1,1,1: only frame 6 detects
    idle_cyc(1'b1);
    pat = 10'b0000111011;
    for (int i = 0; i < 6; i++) begin
      frm(pat[i], 45'd100, 7'd5);
      if (i == 5) expect_hit("t4_f6");
      else check($sformatf("t4_f%0d", i + 1), ifc.det_pulse, 64'd0);
    end
    check("t4_cnt", ifc.det_cnt, 64'(exp_cnt));
    idle_cyc(1'b0);

    // Frame on the vad-rise cycle is ignored
    drive(1'b1, 1'b1, 1'b1, 45'd100, 7'd5);
    check("t5_busy", ifc.busy, 64'd1);
    frm(1'b1, 45'd100, 7'd5); check("t5_f1", ifc.det_pulse, 64'd0);
    frm(1'b1, 45'd100, 7'd5); check("t5_f2", ifc.det_pulse, 64'd0);
    frm(1'b1, 45'd100, 7'd5); expect_hit("t5_f3");
    idle_cyc(1'b0);

    // Continuous hits through the hold-off window
`ifdef DETECT_ONCE_PER_VAD_EN
    pat = 10'b0000000100;
`else
    pat = 10'b1000000100;
`endif
    idle_cyc(1'b1);
    for (int i = 0; i < 10; i++) begin
      frm(1'b1, 45'd100, 7'd5);
      if (pat[i]) expect_hit($sformatf("t6_f%0d", i + 1));
      else check($sformatf("t6_f%0d", i + 1), ifc.det_pulse, 64'd0);
    end
    check("t6_cnt", ifc.det_cnt, 64'(exp_cnt));
    check("t6_busy", ifc.busy, 64'd1);
    idle_cyc(1'b0);
    check("t6_busy_fall", ifc.busy, 64'd0);

    // vad falls together with the third hit
    idle_cyc(1'b1);
    frm(1'b1, 45'd100, 7'd5);
    frm(1'b1, 45'd100, 7'd5);
    drive(1'b0, 1'b1, 1'b1, 45'd100, 7'd5);
    check("t7_nopulse", ifc.det_pulse, 64'd0);
    check("t7_idle", ifc.busy, 64'd0);
    idle_cyc(1'b1);
    frm(1'b1, 45'd100, 7'd5); check("t7_f1", ifc.det_pulse, 64'd0);
    frm(1'b1, 45'd100, 7'd5); check("t7_f2", ifc.det_pulse, 64'd0);
    frm(1'b1, 45'd100, 7'd5); expect_hit("t7_f3");
    idle_cyc(1'b0);

    // len_in = 0 counts as a miss
    idle_cyc(1'b1);
    frm(1'b1, 45'd100, 7'd5); check("t8_f1", ifc.det_pulse, 64'd0);
    frm(1'b1, 45'd100, 7'd5); check("t8_f2", ifc.det_pulse, 64'd0);
    frm(1'b1, 45'd100, 7'd0); check("t8_f3", ifc.det_pulse, 64'd0);
    frm(1'b1, 45'd100, 7'd5); check("t8_f4", ifc.det_pulse, 64'd0);
    frm(1'b1, 45'd100, 7'd5); check("t8_f5", ifc.det_pulse, 64'd0);
    frm(1'b1, 45'd100, 7'd5); expect_hit("t8_f6");
    idle_cyc(1'b0);
    check("pulse_total", 64'(pulse_cnt), 64'(exp_pulses));

    // Reset in the middle of a run
    idle_cyc(1'b1);
    frm(1'b1, 45'd100, 7'd5);
    frm(1'b1, 45'd100, 7'd5);
    @(negedge clk);
    reset = 1'b1; ifc.frame_dv = 1'b1; ifc.hit = 1'b1;
    @(posedge clk);
    #1;
    check("t9_pulse", ifc.det_pulse, 64'd0);
    check("t9_cnt",   ifc.det_cnt,   64'd0);
    check("t9_scr",   ifc.det_scr,   64'd0);
    check("t9_len",   ifc.det_len,   64'd0);
    check("t9_busy",  ifc.busy,      64'd0);
    @(negedge clk);
    reset = 1'b0; ifc.frame_dv = 1'b0; ifc.vad = 1'b0;
    exp_cnt = 0;

    // 256 detections saturate the counter at 255
    base = pulse_cnt;
    for (int i = 0; i < 256; i++) begin
      idle_cyc(1'b1);
      frm(1'b1, 45'd100, 7'd5);
      frm(1'b1, 45'd100, 7'd5);
      frm(1'b1, 45'd100, 7'd5);
      expect_hit($sformatf("t10_det%0d", i + 1));
      if (i >= 253) check($sformatf("t10_cnt%0d", i + 1), ifc.det_cnt, 64'(exp_cnt));
      idle_cyc(1'b0);
    end
    check("t10_cnt_sat", ifc.det_cnt, 64'd255);
    check("t10_pulses", 64'(pulse_cnt - base), 64'd256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
